bram_playback_ctrl: RTL and testbench
=====================================

Name: bram_playback_ctrl

Overview:
Sequences playback of 512-bit waveform words from the PL block RAM onto the axis_0 DAC stream. Software programs GPIO start/stop byte pointers and the DAC enable bit. The block then issues BRAM reads for each word in [start, stop), buffers the read data through a small credit-managed FIFO and presents it on AXI4-Stream with full tready backpressure. It can play the range once or loop over it.

Parameters:
DATA_W, 512, stream and BRAM word width in bits (64 bytes per word)
ADDR_W, 12, BRAM word-address width
RD_LAT, 2, BRAM read latency in cycles, from addr/en to valid dout
FIFO_DEPTH, 4, output buffer depth; must be >= RD_LAT+2

Ports:
clk  in  1  single clock for the block, GPIO and BRAM port B
rst  in  1  asynchronous, active-high reset
enable  in  1  DAC enable (GPIO_DAC bit 0), level-sensitive
loop_en  in  1  1 = wrap to start after the last word; 0 = one pass
start_ptr  in  32  start byte address (GPIO_START)
stop_ptr  in  32  stop byte address, exclusive (GPIO_STOP)
bram_addr  out  ADDR_W  BRAM word address
bram_en  out  1  BRAM read enable
bram_dout  in  DATA_W  BRAM read data, valid RD_LAT cycles after bram_en
m_axis_tdata  out  DATA_W  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  marks the last word of each pass
busy  out  1  state != IDLE
cfg_err  out  1  sticky; set on an invalid pointer pair
pass_cnt  out  16  number of completed passes (tlast handshakes), saturating

Behaviour:
- Reset: every output is 0, state = IDLE, FIFO is empty, no reads are in flight.
- Word index: s = start_ptr[ADDR_W+5:6] and e = stop_ptr[ADDR_W+5:6]. Pointer bits [5:0] are ignored. Example: stop_ptr 0xC00 gives e = 48.
- IDLE, with enable = 1:
  - If e <= s: set cfg_err and stay in IDLE.
  - Otherwise: latch s and e, set rd_ptr = s, clear cfg_err and pass_cnt, and go to RUN.
- RUN read issue:
  - A read is issued (bram_en = 1, bram_addr = rd_ptr) when inflight + fifo_count < FIFO_DEPTH.
  - inflight counts reads issued but not yet written into the FIFO.
  - The pipeline carries a last-tag bit equal to (rd_ptr == e-1).
- Pointer advance:
  - rd_ptr increments by 1 after each issued read.
  - At rd_ptr == e-1: with loop_en = 1, the next read is at s. With loop_en = 0, reads stop and the state goes to DRAIN.
- enable falling during RUN: reads stop immediately and the state goes to DRAIN. The pass is not completed.
- DRAIN: all in-flight reads and FIFO words are streamed out normally. When inflight == 0 and the FIFO is empty, go to IDLE.
- Re-arming: enable must be low in IDLE before a new start is accepted. A level held high after a one-shot pass does not restart playback.
- Stream rules:
  - m_axis_tvalid = FIFO not empty.
  - m_axis_tdata and m_axis_tlast come from the FIFO head.
  - Data and valid are stable while tvalid = 1 and tready = 0, and tvalid is never dropped without a handshake.
- Latency: first word reaches tvalid at RD_LAT+1 cycles after the IDLE->RUN transition edge. Sustained rate is 1 word per cycle while tready = 1.
- pass_cnt increments on each tlast handshake and saturates at 0xFFFF.
- Simultaneous FIFO write and read: allowed, count unchanged. FIFO can never overflow because of the credit check. An overflow is an assertion failure.
- Single-word range (e = s+1): every beat carries tlast.
- Pointer changes during RUN are ignored; they take effect at the next start.
- rst mid-operation: everything is cleared at once. In-flight BRAM data returning after reset is discarded, because the valid pipeline is reset.

Decomposition:
- Package bram_playback_pkg holds:
  - state enum {IDLE, RUN, DRAIN}
  - BYTE_OFS = 6
  - word_t typedef (DATA_W)
- Sub-module playback_fifo: synchronous FIFO of {tlast, tdata}, depth FIFO_DEPTH, with count output and first-word-fall-through.
- The controller holds the FSM, address generator, RD_LAT valid/last shift register, credit logic and pass counter.

Test Plan:
1. One pass: start 0x000, stop 0xC00, loop_en 0, tready 1, BRAM word k = k. Expect 48 beats with data 0..47, tlast only on 47, pass_cnt 1, then busy drops to 0.
2. Backpressure: same setup, tready toggling 1 cycle high / 2 cycles low. Expect the same 48-word sequence, no drops or duplicates, tdata stable while stalled, and never more than FIFO_DEPTH reads outstanding.
3. Loop: start 0x040, stop 0x100, loop_en 1, run 20 beats. Expect data 1,2,3,1,2,3,..., tlast on every word 3, pass_cnt 6 after 18 beats.
4. Invalid config: start 0x100, stop 0x100, then stop 0x080. Expect cfg_err 1, busy 0, tvalid never asserted.
5. Disable mid-stream: loop run of 0..47, drop enable at beat 10 with tready 1. Expect at most FIFO_DEPTH+RD_LAT further beats, in order, then IDLE, with no tlast in that partial pass.
6. Reset mid-stream: assert rst for 1 cycle during RUN with tready 0. Expect tvalid 0, busy 0 and pass_cnt 0 immediately, and no stale beat after release.

Source files
------------

// File: rtl/bram_playback_ctrl_pkg.sv
// bram_playback_pkg: shared types and constants for the BRAM playback controller
package bram_playback_pkg;
    localparam int WORD_W = 512;
    localparam int BYTE_OFS = 6;
    typedef logic [WORD_W-1:0] word_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/bram_playback_ctrl_fifo.sv
// playback_fifo: first-word-fall-through FIFO of {tlast, tdata} with occupancy count
module playback_fifo
    import bram_playback_pkg::*;
#(
    parameter int W = 513,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [W-1:0]  din,
    input  logic          rd,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_rd;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty = count == '0;
    assign do_rd = rd && !empty;
    // Head is forced to zero while empty so idle outputs read as zero
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr ? inc(wr_ptr) : wr_ptr;
            rd_ptr <= do_rd ? inc(rd_ptr) : rd_ptr;
            count <= count + CW'(wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= din;
    end

    always @(posedge clk) begin
        if (!rst) assert (!(wr && !do_rd && count == CW'(DEPTH)));
    end
endmodule

// File: rtl/bram_playback_ctrl.sv
// bram_playback_ctrl: streams a [start, stop) range of BRAM words onto AXI4-Stream,
// once or looping, with credit-based read issue into a small output FIFO.
module bram_playback_ctrl
    import bram_playback_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              loop_en,
    input  logic [31:0]       start_ptr,
    input  logic [31:0]       stop_ptr,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              cfg_err,
    output logic [15:0]       pass_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_t state, state_nx;
    logic [ADDR_W-1:0] s_w, e_w, s_reg, e_reg, rd_ptr;
    logic [RD_LAT-1:0] vld_sr, last_sr;
    logic [CW-1:0] inflight, fifo_count;
    logic armed, issue, last_rd, start, bad_cfg, fifo_empty;
    logic unused_ptr_bits;

    assign s_w = start_ptr[BYTE_OFS +: ADDR_W];
    assign e_w = stop_ptr[BYTE_OFS +: ADDR_W];
    assign unused_ptr_bits = ^{start_ptr[31:BYTE_OFS+ADDR_W], start_ptr[BYTE_OFS-1:0],
                               stop_ptr[31:BYTE_OFS+ADDR_W], stop_ptr[BYTE_OFS-1:0]};

    assign bad_cfg = e_w <= s_w;
    // armed requires enable to have been low since the last start
    assign start = state == IDLE && enable && armed && !bad_cfg;
    assign last_rd = rd_ptr == e_reg - ADDR_W'(1);
    assign issue = state == RUN && enable &&
                   ({1'b0, inflight} + {1'b0, fifo_count} < (CW+1)'(FIFO_DEPTH));
    assign bram_en = issue;
    assign bram_addr = rd_ptr;
    assign busy = state != IDLE;
    assign m_axis_tvalid = !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (!enable || (issue && last_rd && !loop_en)) state_nx = DRAIN;
            DRAIN:   if (inflight == '0 && fifo_empty) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr <= '0;
            last_sr <= '0;
            inflight <= '0;
            s_reg <= '0;
            e_reg <= '0;
            rd_ptr <= '0;
            armed <= 1'b1;
            cfg_err <= 1'b0;
            pass_cnt <= '0;
        end else begin
            vld_sr <= (vld_sr << 1) | RD_LAT'(issue);
            last_sr <= (last_sr << 1) | RD_LAT'(issue && last_rd);
            inflight <= inflight + CW'(issue) - CW'(vld_sr[RD_LAT-1]);
            if (start) begin
                s_reg <= s_w;
                e_reg <= e_w;
                rd_ptr <= s_w;
            end else if (issue) begin
                rd_ptr <= last_rd ? s_reg : rd_ptr + ADDR_W'(1);
            end
            armed <= start ? 1'b0 : (!enable ? 1'b1 : armed);
            if (state == IDLE && enable && armed) cfg_err <= bad_cfg;
            if (start) pass_cnt <= '0;
            else if (m_axis_tvalid && m_axis_tready && m_axis_tlast && pass_cnt != 16'hFFFF)
                pass_cnt <= pass_cnt + 16'd1;
        end
    end

    playback_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (vld_sr[RD_LAT-1]),
        .din   ({last_sr[RD_LAT-1], bram_dout}),
        .rd    (m_axis_tready),
        .dout  ({m_axis_tlast, m_axis_tdata}),
        .empty (fifo_empty),
        .count (fifo_count)
    );
endmodule

// File: tb/tb_bram_playback_ctrl.sv
// tb_bram_playback_ctrl: directed and randomized playback runs against a
// range/loop reference model with a behavioural BRAM.
module tb_bram_playback_ctrl;
    import bram_playback_pkg::*;
    localparam int AW = 12;
    localparam int RL = 2;
    localparam int FD = 4;

    logic clk = 0, rst = 1, enable = 0, loop_en = 0, tready = 0;
    logic [31:0] start_ptr = 0, stop_ptr = 0;
    logic [AW-1:0] bram_addr;
    logic bram_en, tvalid, tlast, busy, cfg_err;
    word_t bram_dout, tdata, p0, p1;
    logic [15:0] pass_cnt;
    word_t mem [0:4095];
    int errors = 0, checks = 0;

    bram_playback_ctrl #(.DATA_W(512), .ADDR_W(AW), .RD_LAT(RL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .enable(enable), .loop_en(loop_en),
        .start_ptr(start_ptr), .stop_ptr(stop_ptr),
        .bram_addr(bram_addr), .bram_en(bram_en), .bram_dout(bram_dout),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast), .busy(busy), .cfg_err(cfg_err), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    // Two-cycle read latency BRAM
    always @(posedge clk) begin
        if (bram_en) p0 <= mem[bram_addr];
        p1 <= p0;
    end
    assign bram_dout = p1;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a run over byte range [sb, eb); after n beats either drop enable (drop)
    // or expect the one-shot pass to end. Every beat is checked against the range model.
    task automatic play(input int sb, input int eb, input bit lp, input int mode,
                        input int n, input bit drop);
        int s = sb / 64, e = eb / 64;
        int len = e - s, got = 0, cyc = 0, fb = -1, fv = -1;
        int issued = 0, hs = 0, maxo = 0, exp_pass = 0, idx;
        bit stall = 0, pl = 0, seen = 0;
        word_t pd = '0;
        @(negedge clk);
        start_ptr = sb; stop_ptr = eb; loop_en = lp; enable = 1;
        while (cyc < 3000 && !(got >= n && !busy && fb >= 0)) begin
            @(negedge clk);
            cyc++;
            tready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 1) : 1'($urandom_range(0, 1));
            if (drop && got >= n) enable = 0;
            #1;
            if (busy && fb < 0) begin
                fb = cyc;
                chk("cfg_err_clear", cfg_err, 0);
            end
            if (tvalid && fv < 0) begin
                fv = cyc;
                chk("first_latency", fv - fb, RL + 1);
            end
            if (stall) begin
                chk("stall_valid", tvalid, 1);
                chk("stall_data", tdata, pd);
                chk("stall_last", tlast, pl);
            end
            chk("pass_cnt", pass_cnt, exp_pass);
            if (bram_en) issued++;
            if (tvalid && tready) begin
                idx = s + got % len;
                chk("beat_data", tdata, mem[idx]);
                chk("beat_last", tlast, idx == e - 1);
                if (idx == e - 1) exp_pass++;
                got++;
                hs++;
            end
            stall = tvalid && !tready;
            pd = tdata;
            pl = tlast;
            if (issued - hs > maxo) maxo = issued - hs;
        end
        chk("run_finished", busy, 0);
        chk("enough_beats", got >= n, 1);
        chk("final_pass_cnt", pass_cnt, exp_pass);
        chk("max_outstanding", maxo <= FD, 1);
        if (drop) chk("drain_beats_bounded", got - n <= FD + RL, 1);
        else chk("one_shot_beats", got, n);
        if (!drop) begin
            repeat (10) begin
                @(negedge clk);
                #1;
                seen |= busy | tvalid;
            end
            chk("no_restart_while_high", seen, 0);
        end
        enable = 0;
        @(negedge clk);
    endtask

    initial begin
        bit seen;
        int s, len;
        bit lp;
        for (int k = 0; k < 4096; k++) begin
            word_t w;
            for (int j = 1; j < 16; j++) w[j*32 +: 32] = $urandom;
            w[31:0] = k;
            mem[k] = w;
        end

        repeat (2) @(negedge clk);
        #1;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_pass_cnt", pass_cnt, 0);
        chk("rst_bram_en", bram_en, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tlast", tlast, 0);
        @(negedge clk);
        rst = 0;

        play(32'h000, 32'hC00, 0, 0, 48, 0);
        play(32'h000, 32'hC00, 0, 1, 48, 0);
        play(32'h040, 32'h100, 1, 0, 20, 1);
        play(32'h080, 32'h0C0, 1, 1, 7, 1);
        play(32'h0BF, 32'h0FF, 0, 0, 1, 0);

        chk("cfg_err_before_bad", cfg_err, 0);
        @(negedge clk);
        start_ptr = 32'h100; stop_ptr = 32'h100; enable = 1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            seen |= tvalid | busy;
        end
        chk("bad_equal_cfg_err", cfg_err, 1);
        stop_ptr = 32'h080;
        repeat (5) begin
            @(negedge clk);
            #1;
            seen |= tvalid | busy;
        end
        chk("bad_reverse_cfg_err", cfg_err, 1);
        chk("bad_no_activity", seen, 0);
        enable = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("cfg_err_sticky", cfg_err, 1);

        play(32'h000, 32'hC00, 1, 0, 10, 1);

        repeat (6) begin
            s = $urandom_range(0, 200);
            len = $urandom_range(1, 10);
            lp = 1'($urandom_range(0, 1));
            play(s * 64 + $urandom_range(0, 63), (s + len) * 64 + $urandom_range(0, 63),
                 lp, 2, lp ? $urandom_range(1, 3 * len) : len, lp);
        end

        @(negedge clk);
        start_ptr = 32'h040; stop_ptr = 32'h080; loop_en = 1; enable = 1; tready = 1;
        repeat (10) @(negedge clk);
        tready = 0;
        repeat (6) @(negedge clk);
        #1;
        chk("pre_reset_valid", tvalid, 1);
        chk("pre_reset_passes", pass_cnt > 0, 1);
        rst = 1;
        enable = 0;
        #1;
        chk("async_rst_tvalid", tvalid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_pass_cnt", pass_cnt, 0);
        chk("async_rst_bram_en", bram_en, 0);
        @(negedge clk);
        rst = 0;
        tready = 1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            seen |= tvalid | busy;
        end
        chk("no_stale_beat", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
